matrix_operand_packer: RTL and testbench

//  Upstream feeder for Large_Matrix_Mult's write port. Accepts matrices A and B
//  as a single-element, row-major valid/ready stream and buffers one full A,B pair.
//  It then emits NUM_ELEMENTS-wide wdata beats in the multiplier's load order:
//  {A[r][c], A[r+1][c], B[r][c], B[r+1][c]}, with r stepping 0,2,.. inside c.

---
 rtl/mm_pkg.sv | 20 ++
 rtl/mm_beat_sel.sv | 41 ++++
 rtl/matrix_operand_packer.sv | 168 ++++++++++++++++
 tb/tb_matrix_operand_packer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply pipeline: default geometry,
// load/emit FSM encoding and row-major element indexing.
package mm_pkg;

    localparam int WIDTH        = 8;
    localparam int MATRIX_WIDTH = 4;
    localparam int NUM_ELEMENTS = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EMIT   = 2'd2
    } mm_state_e;

    // Flat buffer slot of element [row][col] in a row-major mw x mw matrix.
    function automatic int elem_index(input int row, input int col, input int mw);
        return row * mw + col;
    endfunction

endpackage

// File: rtl/mm_beat_sel.sv
// Maps a beat index onto the four buffered elements that form that beat:
// {A[r][c], A[r+1][c], B[r][c], B[r+1][c]} with r stepping by 2 inside c.
module mm_beat_sel #(
    parameter int WIDTH        = mm_pkg::WIDTH,
    parameter int MATRIX_WIDTH = mm_pkg::MATRIX_WIDTH,
    parameter int NUM_ELEMENTS = mm_pkg::NUM_ELEMENTS,
    parameter int BEAT_W       = $clog2(MATRIX_WIDTH * MATRIX_WIDTH / 2)
) (
    input  logic [BEAT_W-1:0]                           beat_idx,
    input  logic [MATRIX_WIDTH*MATRIX_WIDTH*WIDTH-1:0]  buf_a,
    input  logic [MATRIX_WIDTH*MATRIX_WIDTH*WIDTH-1:0]  buf_b,
    output logic [NUM_ELEMENTS*WIDTH-1:0]               beat
);
    import mm_pkg::*;

    localparam int HALF      = MATRIX_WIDTH / 2;
    localparam int NUM_BEATS = MATRIX_WIDTH * MATRIX_WIDTH / 2;

    int col_s;
    int row_s;
    int top_s;
    int bot_s;

    // Decode beat index to column/row pair and gather the four elements.
    always_comb begin
        col_s = int'(beat_idx) / HALF;
        row_s = 2 * (int'(beat_idx) % HALF);
        top_s = elem_index(row_s, col_s, MATRIX_WIDTH);
        bot_s = elem_index(row_s + 1, col_s, MATRIX_WIDTH);
        beat  = '0;
        if (int'(beat_idx) < NUM_BEATS) begin
            beat[4*WIDTH-1:3*WIDTH] = buf_a[top_s*WIDTH +: WIDTH];
            beat[3*WIDTH-1:2*WIDTH] = buf_a[bot_s*WIDTH +: WIDTH];
            beat[2*WIDTH-1:WIDTH]   = buf_b[top_s*WIDTH +: WIDTH];
            beat[WIDTH-1:0]         = buf_b[bot_s*WIDTH +: WIDTH];
        end else begin
            beat = '0;
        end
    end

endmodule

// File: rtl/matrix_operand_packer.sv
// Buffers one A,B matrix pair from a row-major element stream and replays it
// as 4-element wdata beats in the multiplier's column-major load order.
module matrix_operand_packer #(
    parameter int WIDTH        = mm_pkg::WIDTH,
    parameter int MATRIX_WIDTH = mm_pkg::MATRIX_WIDTH,
    parameter int NUM_ELEMENTS = mm_pkg::NUM_ELEMENTS
) (
    input  logic                          w_clk,
    input  logic                          w_reset_n,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_ELEMENTS*WIDTH-1:0] wdata,
    output logic                          w_en,
    input  logic                          w_ready,
    output logic                          busy,
    output logic                          pair_done
);
    import mm_pkg::*;

    localparam int MAT_ELEMS = MATRIX_WIDTH * MATRIX_WIDTH;
    localparam int NUM_BEATS = MAT_ELEMS / 2;
    localparam int CNT_W     = $clog2(MAT_ELEMS);
    localparam int BEAT_W    = $clog2(NUM_BEATS);
    localparam int BUF_W     = MAT_ELEMS * WIDTH;
    localparam int OUT_W     = NUM_ELEMENTS * WIDTH;

    localparam logic [CNT_W-1:0]  LAST_ELEM = CNT_W'(MAT_ELEMS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    mm_state_e          state_q, state_d;
    logic [CNT_W-1:0]   elem_cnt_q, elem_cnt_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [BUF_W-1:0]   buf_a_q, buf_a_d;
    logic [BUF_W-1:0]   buf_b_q, buf_b_d;
    logic [OUT_W-1:0]   wdata_q, wdata_d;
    logic               w_en_q, w_en_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               pair_done_q, pair_done_d;

    logic               accept_s;
    logic               last_elem_s;
    logic [BEAT_W-1:0]  sel_idx_s;
    logic [OUT_W-1:0]   sel_beat_s;

    assign accept_s    = in_valid && in_ready_q;
    assign last_elem_s = (elem_cnt_q == LAST_ELEM);
    // Outside EMIT the next beat to present is always beat 0.
    assign sel_idx_s   = (state_q == EMIT) ? (beat_cnt_q + BEAT_W'(1)) : '0;

    // Buffer B is read through its next value so beat 0 can be loaded on
    // the same edge that captures the final B element.
    mm_beat_sel #(
        .WIDTH        (WIDTH),
        .MATRIX_WIDTH (MATRIX_WIDTH),
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .BEAT_W       (BEAT_W)
    ) u_beat_sel (
        .beat_idx (sel_idx_s),
        .buf_a    (buf_a_q),
        .buf_b    (buf_b_d),
        .beat     (sel_beat_s)
    );

    // Element capture into the A/B buffers at the current element slot.
    always_comb begin
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        if (accept_s && (state_q == LOAD_A)) begin
            buf_a_d[elem_cnt_q*WIDTH +: WIDTH] = in_data;
        end else if (accept_s && (state_q == LOAD_B)) begin
            buf_b_d[elem_cnt_q*WIDTH +: WIDTH] = in_data;
        end else begin
            buf_a_d = buf_a_q;
        end
    end

    // Load/emit sequencing, counters and output register next values.
    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        wdata_d     = wdata_q;
        w_en_d      = w_en_q;
        pair_done_d = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (accept_s) begin
                    elem_cnt_d = last_elem_s ? '0 : elem_cnt_q + CNT_W'(1);
                    state_d    = last_elem_s ? LOAD_B : LOAD_A;
                end else begin
                    elem_cnt_d = elem_cnt_q;
                end
            end
            LOAD_B: begin
                if (accept_s && last_elem_s) begin
                    elem_cnt_d = '0;
                    beat_cnt_d = '0;
                    state_d    = EMIT;
                    w_en_d     = 1'b1;
                    wdata_d    = sel_beat_s;
                end else if (accept_s) begin
                    elem_cnt_d = elem_cnt_q + CNT_W'(1);
                end else begin
                    elem_cnt_d = elem_cnt_q;
                end
            end
            EMIT: begin
                if (w_en_q && w_ready && (beat_cnt_q == LAST_BEAT)) begin
                    state_d     = LOAD_A;
                    beat_cnt_d  = '0;
                    w_en_d      = 1'b0;
                    wdata_d     = '0;
                    pair_done_d = 1'b1;
                end else if (w_en_q && w_ready) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    wdata_d    = sel_beat_s;
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = LOAD_A;
                elem_cnt_d = '0;
                beat_cnt_d = '0;
                w_en_d     = 1'b0;
                wdata_d    = '0;
            end
        endcase
        in_ready_d = (state_d != EMIT);
        busy_d     = (state_d != LOAD_A) || (elem_cnt_d != '0);
    end

    // State, buffer and output registers.
    always_ff @(posedge w_clk or negedge w_reset_n) begin
        if (!w_reset_n) begin
            state_q     <= LOAD_A;
            elem_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            buf_a_q     <= '0;
            buf_b_q     <= '0;
            wdata_q     <= '0;
            w_en_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            pair_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            buf_a_q     <= buf_a_d;
            buf_b_q     <= buf_b_d;
            wdata_q     <= wdata_d;
            w_en_q      <= w_en_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            pair_done_q <= pair_done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign wdata     = wdata_q;
    assign w_en      = w_en_q;
    assign busy      = busy_q;
    assign pair_done = pair_done_q;

endmodule

// File: tb/tb_matrix_operand_packer.sv
// Scoreboard bench for matrix_operand_packer: expected beats are queued when
// a pair is loaded and matched against beats observed on w_en && w_ready.
module tb_matrix_operand_packer;

    logic        w_clk = 1'b0;
    logic        w_reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] wdata;
    logic        w_en;
    logic        w_ready;
    logic        busy;
    logic        pair_done;

    int compared   = 0;
    int mismatched = 0;
    int pd_cnt     = 0;
    int acc_cnt    = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [7:0]  ma[16];
    logic [7:0]  mb[16];

    always #5 w_clk = ~w_clk;

    matrix_operand_packer dut (
        .w_clk     (w_clk),
        .w_reset_n (w_reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wdata     (wdata),
        .w_en      (w_en),
        .w_ready   (w_ready),
        .busy      (busy),
        .pair_done (pair_done)
    );

    // Monitor: record transferred beats, pair_done pulses and accepted elements.
    always @(posedge w_clk) begin
        if (w_reset_n && w_en && w_ready) obs_q.push_back(wdata);
        if (w_reset_n && pair_done) pd_cnt <= pd_cnt + 1;
        if (w_reset_n && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic load_mats(input logic [7:0] oa, input logic [7:0] ob);
        for (int i = 0; i < 16; i++) begin
            ma[i] = 8'h01 + oa + 8'(i);
            mb[i] = 8'h11 + ob + 8'(i);
        end
    endtask

    task automatic push_expected();
        for (int b = 0; b < 8; b++) begin
            int c;
            int r;
            c = b / 2;
            r = 2 * (b % 2);
            exp_q.push_back({ma[r*4+c], ma[(r+1)*4+c], mb[r*4+c], mb[(r+1)*4+c]});
        end
    endtask

    task automatic send_elem(input logic [7:0] d);
        int   n;
        logic ok;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        do begin
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 300);
        in_valid = 1'b0;
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL send_elem_timeout: in_ready stayed %b, required 1", in_ready);
        end
    endtask

    task automatic stream(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_elem(i < 16 ? ma[i] : mb[i-16]);
        end
    endtask

    task automatic wait_pairs(input int target);
        int n;
        n = 0;
        while (pd_cnt < target && n < 400) begin
            tick();
            n++;
        end
        compared++;
        if (pd_cnt !== target) begin
            mismatched++;
            $display("FAIL pair_done_count: got %0d, required %0d", pd_cnt, target);
        end
    endtask

    task automatic drain_scoreboard(input string name);
        logic [31:0] e;
        logic [31:0] o;
        int          k;
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL %s beat_count: got %0d, required %0d", name, obs_q.size(), exp_q.size());
        end
        k = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL %s beat%0d: got %h, required %h", name, k, o, e);
            end
            k++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        w_reset_n = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        w_ready   = 1'b0;
        repeat (3) tick();
        w_reset_n = 1'b1;
        tick();
        compared++;
        if ({in_ready, w_en, busy, pair_done} !== 4'b1000 || wdata !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_state: rdy/en/busy/done=%b wdata=%h, required 1000 / 00000000",
                     {in_ready, w_en, busy, pair_done}, wdata);
        end
    endtask

    task automatic test_stream();
        int pd0;
        pd0 = pd_cnt;
        w_ready = 1'b1;
        load_mats(8'h00, 8'h00);
        push_expected();
        stream(0, 31);
        compared++;
        if (w_en !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL stream_latency: w_en=%b in_ready=%b busy=%b, required 1 0 1", w_en, in_ready, busy);
        end
        for (int k = 0; k < 8; k++) begin
            compared++;
            if (w_en !== 1'b1) begin
                mismatched++;
                $display("FAIL stream_consecutive beat%0d: w_en=%b, required 1", k, w_en);
            end
            tick();
        end
        compared++;
        if ({w_en, pair_done, in_ready, busy} !== 4'b0110 || wdata !== 32'h0) begin
            mismatched++;
            $display("FAIL stream_end: en/done/rdy/busy=%b wdata=%h, required 0110 / 00000000",
                     {w_en, pair_done, in_ready, busy}, wdata);
        end
        tick();
        compared++;
        if (pair_done !== 1'b0) begin
            mismatched++;
            $display("FAIL stream_done_pulse: pair_done=%b, required 0", pair_done);
        end
        compared++;
        if (obs_q.size() != 8) begin
            mismatched++;
            $display("FAIL stream_known_beats: got %0d beats, required 8", obs_q.size());
        end else if (obs_q[0] !== 32'h01051115 || obs_q[1] !== 32'h090D191D || obs_q[7] !== 32'h0C101C20) begin
            mismatched++;
            $display("FAIL stream_known_beats: got %h %h %h, required 01051115 090d191d 0c101c20",
                     obs_q[0], obs_q[1], obs_q[7]);
        end
        drain_scoreboard("stream");
        wait_pairs(pd0 + 1);
    endtask

    task automatic test_stall();
        int          pd0;
        logic [31:0] held;
        logic        stall;
        pd0 = pd_cnt;
        w_ready = 1'b0;
        load_mats(8'h00, 8'h00);
        push_expected();
        stream(0, 31);
        for (int k = 0; k < 200; k++) begin
            w_ready = (k % 4 == 0) || (k % 4 == 3);
            held    = wdata;
            stall   = w_en && !w_ready;
            tick();
            if (stall) begin
                compared++;
                if (w_en !== 1'b1 || wdata !== held) begin
                    mismatched++;
                    $display("FAIL stall_hold cycle%0d: w_en=%b wdata=%h, required 1 %h", k, w_en, wdata, held);
                end
            end
            if (pair_done === 1'b1) break;
        end
        w_ready = 1'b1;
        wait_pairs(pd0 + 1);
        drain_scoreboard("stall");
    endtask

    task automatic test_valid_in_emit();
        int a0;
        int n;
        w_ready = 1'b1;
        load_mats(8'h00, 8'h00);
        push_expected();
        stream(0, 31);
        a0 = acc_cnt;
        in_data  = 8'h99;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        compared++;
        if (acc_cnt !== a0 || n !== 8) begin
            mismatched++;
            $display("FAIL emit_ignores_valid: accepted %0d in %0d cycles, required 0 in 8", acc_cnt - a0, n);
        end
        tick();
        in_valid = 1'b0;
        compared++;
        if (acc_cnt !== a0 + 1 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL boundary_accept: accepted %0d busy=%b, required 1 1", acc_cnt - a0, busy);
        end
        drain_scoreboard("emit_valid_pair1");
        ma[0] = 8'h99;
        push_expected();
        stream(1, 31);
        wait_pairs(pd_cnt + 1);
        drain_scoreboard("emit_valid_pair2");
    endtask

    task automatic test_reset_mid_load();
        w_ready = 1'b1;
        load_mats(8'h00, 8'h00);
        stream(0, 19);
        w_reset_n = 1'b0;
        repeat (2) tick();
        w_reset_n = 1'b1;
        repeat (3) tick();
        compared++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL load_abort: busy=%b in_ready=%b beats=%0d, required 0 1 0", busy, in_ready, obs_q.size());
        end
        push_expected();
        stream(0, 31);
        wait_pairs(pd_cnt + 1);
        drain_scoreboard("after_load_abort");
    endtask

    task automatic test_reset_mid_emit();
        int pd0;
        w_ready = 1'b1;
        load_mats(8'h00, 8'h00);
        push_expected();
        stream(0, 31);
        repeat (4) tick();
        pd0 = pd_cnt;
        #2;
        w_reset_n = 1'b0;
        #1;
        compared++;
        if ({w_en, in_ready, busy} !== 3'b010 || wdata !== 32'h0) begin
            mismatched++;
            $display("FAIL emit_abort_async: en/rdy/busy=%b wdata=%h, required 010 / 00000000",
                     {w_en, in_ready, busy}, wdata);
        end
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        drain_scoreboard("before_emit_abort");
        repeat (2) tick();
        w_reset_n = 1'b1;
        repeat (10) tick();
        compared++;
        if (obs_q.size() != 0 || pd_cnt !== pd0 || w_en !== 1'b0) begin
            mismatched++;
            $display("FAIL emit_abort_quiet: beats=%0d pulses=%0d w_en=%b, required 0 0 0",
                     obs_q.size(), pd_cnt - pd0, w_en);
        end
    endtask

    task automatic test_back_to_back();
        int pd0;
        pd0 = pd_cnt;
        w_ready = 1'b1;
        load_mats(8'h00, 8'h00);
        push_expected();
        stream(0, 31);
        load_mats(8'h40, 8'h40);
        push_expected();
        stream(0, 31);
        wait_pairs(pd0 + 2);
        compared++;
        if (obs_q.size() != 16) begin
            mismatched++;
            $display("FAIL b2b_second_beat0: got %0d beats, required 16", obs_q.size());
        end else if (obs_q[8] !== 32'h41455155) begin
            mismatched++;
            $display("FAIL b2b_second_beat0: got %h, required 41455155", obs_q[8]);
        end
        drain_scoreboard("back_to_back");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_valid_in_emit();
        test_reset_mid_load();
        test_reset_mid_emit();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
